// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle: raw sensors and enable in, coin code and status out.
// master is the acceptor side, slave is the vending controller / sensor side.
interface coin_acceptor_if;
   logic       sense_one;
   logic       sense_two;
   logic       en;
   logic [1:0] coin;
   logic       full;
   logic       reject;
   logic [7:0] total;

   modport master (
      input  sense_one, sense_two, en,
      output coin, full, reject, total
   );

   modport slave (
      output sense_one, sense_two, en,
      input  coin, full, reject, total
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronise and debounce two coin sensors, queue accepted coins,
// and transmit one single-cycle code per coin followed by GAP idle cycles.
module coin_acceptor #(
   parameter int unsigned DEBOUNCE = 4,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned GAP      = 1
) (
   input logic            clk,
   input logic            rst,
   coin_acceptor_if.master bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEBOUNCE + 1);
   localparam int unsigned GW = $clog2(GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t        state;
   logic [1:0]    sync_one, sync_two;
   logic [CW-1:0] cnt_one, cnt_two;
   logic          arm_one, arm_two;
   logic          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nxt;
   logic [GW-1:0] gcnt;
   logic          det_one, det_two, start, push, drop;
   logic [8:0]    sum;

   always_comb begin
      det_one   = sync_one[1] && arm_one && (cnt_one == CW'(DEBOUNCE - 1));
      det_two   = sync_two[1] && arm_two && (cnt_two == CW'(DEBOUNCE - 1));
      // The last gap cycle doubles as IDLE so queued codes come out every GAP+1 cycles.
      start     = bus.en && (count != '0) &&
                  ((state == S_IDLE) || ((state == S_GAP) && (gcnt == GW'(1))));
      push      = (det_one ^ det_two) && ((count != (AW+1)'(DEPTH)) || start);
      drop      = (det_one && det_two) || ((det_one ^ det_two) && !push);
      count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, start};
      sum       = {1'b0, bus.total} + (bus.coin[0] ? 9'd2 : 9'd1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_one   <= '0;
         sync_two   <= '0;
         cnt_one    <= '0;
         cnt_two    <= '0;
         arm_one    <= 1'b0;
         arm_two    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         gcnt       <= '0;
         state      <= S_IDLE;
         bus.coin   <= '0;
         bus.full   <= 1'b0;
         bus.reject <= 1'b0;
         bus.total  <= '0;
      end else begin
         sync_one <= {sync_one[0], bus.sense_one};
         sync_two <= {sync_two[0], bus.sense_two};

         if (!sync_one[1]) begin
            cnt_one <= '0;
            arm_one <= 1'b1;
         end else begin
            if (cnt_one != CW'(DEBOUNCE)) cnt_one <= cnt_one + 1'b1;
            if (det_one) arm_one <= 1'b0;
         end

         if (!sync_two[1]) begin
            cnt_two <= '0;
            arm_two <= 1'b1;
         end else begin
            if (cnt_two != CW'(DEBOUNCE)) cnt_two <= cnt_two + 1'b1;
            if (det_two) arm_two <= 1'b0;
         end

         if (push) begin
            mem[wr_ptr] <= det_two;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (start) rd_ptr <= rd_ptr + 1'b1;
         count      <= count_nxt;
         bus.full   <= (count_nxt == (AW+1)'(DEPTH));
         bus.reject <= drop;

         if (start) begin
            bus.coin <= {1'b1, mem[rd_ptr]};
            state    <= S_SEND;
         end else begin
            case (state)
               S_SEND: begin
                  bus.coin  <= '0;
                  bus.total <= sum[8] ? '1 : sum[7:0];
                  gcnt      <= GW'(GAP);
                  state     <= S_GAP;
               end
               S_GAP: begin
                  bus.coin <= '0;
                  gcnt     <= gcnt - 1'b1;
                  if (gcnt == GW'(1)) state <= S_IDLE;
               end
               default: begin
                  bus.coin <= '0;
                  state    <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin acceptor that drives the 2-bit `coin` code consumed by the vending machine controller. It synchronises and debounces the raw 1-rupee and 2-rupee validator sensors and queues accepted coins in a small FIFO. It then transmits one code per coin as a single-cycle pulse followed by idle gap cycles. It also reports queue-full rejects and a running total of value delivered.

## Interface
- `DEBOUNCE`, 4: consecutive synchronised-high cycles required to accept a coin (≥2).
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `GAP`, 1: forced `00` cycles after each sent code (≥1).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `sense_one`  in  1  raw 1-rupee sensor, asynchronous, may bounce.
- `sense_two`  in  1  raw 2-rupee sensor, asynchronous, may bounce.
- `en`  in  1  transmit enable; low holds the queue and forces `coin=00`.
- `coin`  out  2  registered code: `00` none, `10` 1 rupee, `11` 2 rupees; `01` never driven.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `reject`  out  1  one-cycle pulse: coin diverted to return chute.
- `total`  out  8  rupees transmitted since reset, saturating at 255.

## Operation
- Reset (`rst=0` at an edge) clears synchronisers, debounce counters, arm flags, FIFO, FSM (→IDLE) and `total`; `coin=00`, `full=0`, `reject=0`, `total=0` after that edge. This applies mid-transmission too: a pending code is dropped, not completed.
- Each sensor passes through a 2-flop synchroniser and then a per-sensor counter.
  - Counter increments while the synchronised level is 1; it clears when the level is 0.
  - A detect fires on the edge where the counter reaches `DEBOUNCE`, once per high period.
  - The sensor re-arms only after its synchronised level returns to 0.
  - Pulses shorter than `DEBOUNCE` cycles are ignored.
- Both sensors detect on the same edge: illegal. Pulse `reject`, push nothing.
- Push: detect writes 1 bit (0=1 rupee, 1=2 rupees).
  - Accepted if the FIFO is not full, or a pop occurs on the same edge.
  - Otherwise pulse `reject` and drop the coin.
- FSM, states IDLE, SEND, GAP:
  - IDLE: if `en=1` and FIFO non-empty, pop the head, drive `coin={1,bit}` and go to SEND. Otherwise `coin=00`.
  - SEND: one cycle only. `coin` becomes `00` next edge. `total += 1 or 2` (saturating) on that edge. Go to GAP with the gap counter at `GAP`.
  - GAP: `coin=00`. Decrement the counter; return to IDLE when it expires. A new code can therefore start no earlier than `GAP+1` edges after the previous one.
- `en=0` in SEND/GAP does not abort; `en` is only sampled in IDLE.
- Codes are transmitted in FIFO order; pointers wrap modulo `DEPTH`; the occupancy counter is `log2(DEPTH)+1` bits.

## Timing
- Sensor first sampled high at edge k, FIFO empty, FSM IDLE, `en=1`:
  - detect/push at edge k+1+`DEBOUNCE`;
  - `coin` code visible after edge k+2+`DEBOUNCE`;
  - `coin` back to `00` after edge k+3+`DEBOUNCE`.
- `reject` is registered, high for exactly the cycle after the offending detect edge.
- `full` is registered and updates on the same edge as the push/pop that changes occupancy.
- Back-to-back queued coins appear every `GAP+1` cycles.
- `total` updates on the edge that ends SEND.

## Test plan
- Reset → `coin=00`, `full=0`, `reject=0`, `total=0`. Parameters `DEBOUNCE=4`, `GAP=1`, `DEPTH=4` for all scenarios.
- `sense_two` high from edge 10 for 8 cycles → `coin=11` for the cycle after edge 16, `00` after edge 17; `total=2`.
- `sense_one` pulse of 3 cycles, then 0, then bouncing 1/0 every cycle → `coin` stays `00`, `total=0`.
- `en=0`; insert 5 one-rupee coins → `full=1` after the 4th push, `reject` pulses once on the 5th. `en=1` → four `10` codes spaced 2 cycles apart; `total=4`.
- Both sensors high together for 8 cycles → `reject` pulses once, no code sent, `total` unchanged.
- Queue two 2-rupee coins, assert `rst=0` during the first SEND → `coin=00` after the reset edge, FIFO empty, `total=0`, no further codes.
